uart_rx_oversample: RTL and testbench

- 16x-oversampling UART receive front end with majority-vote bit sampling.
- Sits between the pmod RX pin and the rx fifo. Produces parallel words through a valid/ready handshake; the fifo write side drives ready as `!full`.
- Configuration inputs come directly from the memory-mapped register bits (rx setup, rx clock divider). Field encodings match the existing uart_tx.
- Adds sticky parity, frame and overrun error reporting for the rx setup register.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_os_tick.sv | 27 ++
 rtl/uart_rx_oversample.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int BPW_MAX    = 15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] clamp_bpw(input logic [4:0] bpw);
    return (bpw > 5'(BPW_MAX)) ? 4'(BPW_MAX) : bpw[3:0];
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one tick every clk_div+1 clocks, phase reset by restart.
module uart_os_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 restart,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // >= rather than == so a divider lowered below the current count wraps at once
  assign tick = (cnt_q >= clk_div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receive front end: 2-FF sync, 16x tick sampling with 2-of-3 vote, valid/ready output.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a synchronised falling edge
// START  | validating the start bit (false start returns to IDLE)
// DATA   | shifting in bits_per_word+1 data bits, LSB first
// PARITY | checking the parity bit
// STOP1  | checking the first stop bit
// STOP2  | checking the second stop bit
module uart_rx_oversample #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [4:0]            bits_per_word,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop_bit,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  parity_error,
  output logic                  frame_error,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                  break_det,
`endif
  output logic                  overrun
);

  import uart_pkg::*;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  rx_state_e             state_q, state_d;
  logic [2:0]            sync_q, sync_d;
  logic [3:0]            idx_q, idx_d;
  logic [1:0]            smp_q, smp_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            bpw_q, bpw_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  two_stop_q, two_stop_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  logic rx_s, start_edge, start_det, tick, smp_tick, last_tick, bit_val;
  logic is_break, armed;
  logic word_done, set_perr, set_ferr;

  assign rx_s       = sync_q[1];
  assign start_edge = sync_q[2] & ~sync_q[1];
  assign start_det  = (state_q == ST_IDLE) && start_edge && armed;
  assign smp_tick   = tick && (idx_q == 4'(SAMPLE_HI));
  assign last_tick  = tick && (idx_q == TICK_LAST);
  assign bit_val    = maj3(smp_q[0], smp_q[1], rx_s);

  uart_os_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .restart (start_det),
    .tick    (tick)
  );

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit_q, par_bit_d;
  logic brk_wait_q, brk_wait_d;
  logic break_det_q, break_det_d;

  assign is_break = (state_q == ST_STOP1) && !bit_val && (shreg_q == '0) &&
                    !(par_en_q && par_bit_q);
  assign armed    = !brk_wait_q;

  always_comb begin
    par_bit_d   = par_bit_q;
    brk_wait_d  = brk_wait_q;
    break_det_d = is_break && smp_tick;
    if (state_q == ST_PARITY && smp_tick) par_bit_d = bit_val;
    // after a break the line must be seen high on a tick before edges count again
    if (is_break && smp_tick)                           brk_wait_d = 1'b1;
    else if (state_q == ST_IDLE && tick && rx_s)        brk_wait_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit_q   <= 1'b0;
      brk_wait_q  <= 1'b0;
      break_det_q <= 1'b0;
    end else begin
      par_bit_q   <= par_bit_d;
      brk_wait_q  <= brk_wait_d;
      break_det_q <= break_det_d;
    end
  end

  assign break_det = break_det_q;
`else
  assign is_break = 1'b0;
  assign armed    = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_det) state_d = ST_START;
      ST_START: begin
        if (smp_tick && bit_val) state_d = ST_IDLE;
        else if (last_tick)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_tick && (bit_cnt_q == bpw_q))
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (last_tick) state_d = ST_STOP1;
      ST_STOP1: begin
        if (smp_tick && (is_break || !two_stop_q)) state_d = ST_IDLE;
        else if (last_tick)                        state_d = ST_STOP2;
      end
      ST_STOP2:  if (smp_tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    word_done = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (smp_tick) begin
      case (state_q)
        ST_PARITY: set_perr = (bit_val != ((^shreg_q) ^ par_odd_q));
        ST_STOP1: begin
          if (!is_break) begin
            set_ferr  = !bit_val;
            word_done = !two_stop_q;
          end
        end
        ST_STOP2: begin
          set_ferr  = !bit_val;
          word_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sync_d     = {sync_q[1:0], rx};
    idx_d      = idx_q;
    smp_d      = smp_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    bpw_d      = bpw_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;

    if (start_det) begin
      idx_d      = '0;
      bit_cnt_d  = '0;
      shreg_d    = '0;
      bpw_d      = clamp_bpw(bits_per_word);
      par_en_d   = parity_en;
      par_odd_d  = parity_odd;
      two_stop_d = two_stop_bit;
    end else if (tick && state_q != ST_IDLE) begin
      idx_d = idx_q + 4'd1;
    end

    if (tick && idx_q == 4'(SAMPLE_LO))  smp_d[0] = rx_s;
    if (tick && idx_q == 4'(SAMPLE_MID)) smp_d[1] = rx_s;

    if (state_q == ST_DATA && smp_tick)  shreg_d[bit_cnt_q] = bit_val;
    if (state_q == ST_DATA && last_tick) bit_cnt_d = bit_cnt_q + 4'd1;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && data_ready) valid_d = 1'b0;
    // a full holding register with no consumer keeps the old word
    if (word_done && !(valid_q && !data_ready)) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end
    perr_d = (perr_q && !err_clr) || set_perr;
    ferr_d = (ferr_q && !err_clr) || set_ferr;
    ovr_d  = (ovr_q && !err_clr) || (word_done && valid_q && !data_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 3'b111;
      idx_q      <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      bpw_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      idx_q      <= idx_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      bpw_q      <= bpw_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frame table plus latency, overrun, glitch and reset sequences.
module tb_uart_rx_oversample;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] clk_div;
  logic [4:0]  bits_per_word;
  logic        parity_en, parity_odd, two_stop_bit, err_clr, data_ready;
  logic [15:0] data_out;
  logic        data_valid, busy, parity_error, frame_error, overrun;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        break_det;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_oversample dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .clk_div       (clk_div),
    .bits_per_word (bits_per_word),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .two_stop_bit  (two_stop_bit),
    .err_clr       (err_clr),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .busy          (busy),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det     (break_det),
`endif
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] word;
    logic [4:0]  bpw;
    bit          pen;
    bit          podd;
    bit          pflip;
    bit          stop1;
    bit          two;
    bit          stop2;
    logic [15:0] div;
    logic [15:0] exp_data;
    bit          exp_perr;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[10];
  int   n_vecs;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] word, input int nbits, input bit pen,
                            input bit pbit, input bit s1, input bit two, input bit s2,
                            input int bitclk);
    rx = 1'b0;
    repeat (bitclk) step();
    for (int i = 0; i < nbits; i++) begin
      rx = word[i];
      repeat (bitclk) step();
    end
    if (pen) begin
      rx = pbit;
      repeat (bitclk) step();
    end
    rx = s1;
    repeat (bitclk) step();
    if (two) begin
      rx = s2;
      repeat (bitclk) step();
    end
    rx = 1'b1;
    repeat (2 * bitclk) step();
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!data_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    vec_t t;
    int   nb, bc, n, cnt;
    logic par;
    bit   saw_busy, saw_valid;

    //          word     bpw  pen podd flip s1 two s2 div    exp     perr ferr
    vecs[0] = '{16'h00A5, 5'd7,  0, 0, 0, 1, 0, 1, 16'd0, 16'h00A5, 0, 0};
    vecs[1] = '{16'h1234, 5'd15, 1, 1, 0, 1, 0, 1, 16'd0, 16'h1234, 0, 0};
    vecs[2] = '{16'h1234, 5'd15, 1, 1, 1, 1, 0, 1, 16'd0, 16'h1234, 1, 0};
    vecs[3] = '{16'h0055, 5'd7,  0, 0, 0, 0, 0, 1, 16'd0, 16'h0055, 0, 1};
    vecs[4] = '{16'h00FF, 5'd3,  0, 0, 0, 1, 0, 1, 16'd1, 16'h000F, 0, 0};
    vecs[5] = '{16'hBEEF, 5'd20, 0, 0, 0, 1, 0, 1, 16'd0, 16'hBEEF, 0, 0};
    vecs[6] = '{16'h0003, 5'd1,  1, 0, 0, 1, 0, 1, 16'd2, 16'h0003, 0, 0};
    vecs[7] = '{16'h0081, 5'd7,  0, 0, 0, 1, 1, 0, 16'd0, 16'h0081, 0, 1};
    vecs[8] = '{16'h001F, 5'd4,  1, 0, 0, 1, 1, 1, 16'd3, 16'h001F, 0, 0};
    n_vecs = 9;
`ifndef UART_RX_BREAK_DETECT_EN
    vecs[9] = '{16'h0000, 5'd7,  0, 0, 0, 0, 0, 1, 16'd0, 16'h0000, 0, 1};
    n_vecs = 10;
`endif

    rst = 1'b1; rx = 1'b1; clk_div = 16'd0; bits_per_word = 5'd7;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop_bit = 1'b0;
    err_clr = 1'b0; data_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("reset_outputs", {data_out, data_valid, busy, parity_error, frame_error, overrun}, 32'h0);

    // start-edge to data_valid latency at clk_div=0
    fork
      send_frame(16'h00A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
      begin
        n = 0;
        while (!busy && n < 100) begin step(); n++; end
        check("latency_busy_seen", busy, 1);
        cnt = 0;
        while (!data_valid && cnt < 400) begin step(); cnt++; end
        check("latency_a5_clocks", cnt, 154);
      end
    join
    check("latency_a5_data", data_out, 16'h00A5);
    consume();

    for (int v = 0; v < n_vecs; v++) begin
      t = vecs[v];
      clk_div = t.div; bits_per_word = t.bpw; parity_en = t.pen;
      parity_odd = t.podd; two_stop_bit = t.two;
      nb  = (t.bpw > 5'd15) ? 16 : int'(t.bpw) + 1;
      bc  = 16 * (int'(t.div) + 1);
      par = t.podd ^ t.pflip;
      for (int i = 0; i < nb; i++) par ^= t.word[i];
      clear_errs();
      check($sformatf("vec%0d_flags_cleared", v), {parity_error, frame_error, overrun}, 3'b000);
      send_frame(t.word, nb, t.pen, par, t.stop1, t.two, t.stop2, bc);
      wait_valid(100);
      check($sformatf("vec%0d_valid", v), data_valid, 1);
      check($sformatf("vec%0d_data", v), data_out, t.exp_data);
      check($sformatf("vec%0d_parity_error", v), parity_error, t.exp_perr);
      check($sformatf("vec%0d_frame_error", v), frame_error, t.exp_ferr);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
      check($sformatf("vec%0d_busy_idle", v), busy, 0);
      consume();
      check($sformatf("vec%0d_valid_cleared", v), data_valid, 0);
    end

    // overrun: second word dropped, first word kept
    clk_div = 16'd0; bits_per_word = 5'd7; parity_en = 1'b0; two_stop_bit = 1'b0;
    clear_errs();
    send_frame(16'h0011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    send_frame(16'h0022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    check("overrun_valid", data_valid, 1);
    check("overrun_data_kept", data_out, 16'h0011);
    check("overrun_flag", overrun, 1);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("overrun_valid_cleared", data_valid, 0);

    // 4-clock glitch at clk_div=3 must be rejected as a false start
    clk_div = 16'd3;
    clear_errs();
    repeat (20) step();
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    saw_busy = 1'b0; saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      saw_busy  |= busy;
      saw_valid |= data_valid;
    end
    check("glitch_busy_seen", saw_busy, 1);
    check("glitch_no_valid", saw_valid, 0);
    check("glitch_busy_dropped", busy, 0);
    check("glitch_no_flags", {parity_error, frame_error, overrun}, 3'b000);

    // reset mid-DATA with a pending word and a sticky flag
    clk_div = 16'd0;
    send_frame(16'h005A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("pre_reset_valid", data_valid, 1);
    rx = 1'b0; repeat (16) step();
    rx = 1'b1; repeat (16) step();
    rx = 1'b0; repeat (16) step();
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #2;
    check("reset_mid_frame_outputs",
          {data_out, data_valid, busy, parity_error, frame_error, overrun}, 32'h0);
    rx = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    send_frame(16'h003C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    wait_valid(100);
    check("post_reset_valid", data_valid, 1);
    check("post_reset_data", data_out, 16'h003C);
    check("post_reset_flags", {parity_error, frame_error, overrun}, 3'b000);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
